// File: rtl/bare_mem_pkg.sv
// Shared types and helpers for the bare-metal harness memory router.
// Contents:
//   region_e        - decoded target of a request
//   tohost_state_e  - pass/fail state of the tohost mailbox
//   in_range        - overflow-safe window hit test
//   offset          - byte offset of an address inside a window
//   default region base/length constants
package bare_mem_pkg;

    typedef enum logic [1:0] {
        REGION_ROM      = 2'd0,
        REGION_SRAM     = 2'd1,
        REGION_TOHOST   = 2'd2,
        REGION_UNMAPPED = 2'd3
    } region_e;

    // Encoding is visible on status_o, so the values are fixed.
    typedef enum logic [1:0] {
        ST_RUNNING = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_BADCODE = 2'd3
    } tohost_state_e;

    // Widest address the helpers accept.
    localparam int MaxAddrWidth = 64;

    localparam logic [63:0] DefRomBase      = 64'h0000_0000_0001_0000;
    localparam logic [63:0] DefRomLength    = 64'h0000_0000_0001_0000;
    localparam logic [63:0] DefDramBase     = 64'h0000_0000_8000_0000;
    localparam logic [63:0] DefDramLength   = 64'h0000_0000_4000_0000;
    localparam logic [63:0] DefTohostBase   = 64'h0000_0000_4000_0000;
    localparam logic [63:0] DefTohostLength = 64'h0000_0000_0000_1000;

    // Operands carry one spare bit so base+len never wraps around.
    function automatic logic in_range(input logic [MaxAddrWidth:0] addr,
                                      input logic [MaxAddrWidth:0] base,
                                      input logic [MaxAddrWidth:0] len);
        return (addr >= base) && (addr < (base + len));
    endfunction

    function automatic logic [MaxAddrWidth-1:0] offset(input logic [MaxAddrWidth-1:0] addr,
                                                       input logic [MaxAddrWidth-1:0] base);
        return addr - base;
    endfunction

endpackage

// File: rtl/bare_tohost_fsm.sv
// Tohost mailbox register and pass/fail state machine.
// Ports:
//   clk_i, rst_i  - clock, asynchronous active-high reset
//   wr_i          - a tohost write is being accepted this cycle
//   be_i, wdata_i - byte enables / data of that write
//   tohost_o      - current mailbox contents
//   status_o      - tohost_state_e encoding (RUNNING/PASS/FAIL/BADCODE)
//   done_o        - status_o is not RUNNING
module bare_tohost_fsm
    import bare_mem_pkg::*;
#(
    parameter int DataWidth = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wr_i,
    input  logic [DataWidth/8-1:0] be_i,
    input  logic [DataWidth-1:0]   wdata_i,
    output logic [DataWidth-1:0]   tohost_o,
    output logic [1:0]             status_o,
    output logic                   done_o
);

    tohost_state_e        state_reg, state_next;
    logic [DataWidth-1:0] tohost_reg, tohost_next;
    logic [DataWidth-1:0] merged;

    // Byte-wise merge used by partial-enable writes.
    for (genvar gi = 0; gi < DataWidth/8; gi++) begin : g_merge
        assign merged[gi*8 +: 8] = be_i[gi] ? wdata_i[gi*8 +: 8] : tohost_reg[gi*8 +: 8];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg  <= ST_RUNNING;
            tohost_reg <= '0;
        end else begin
            state_reg  <= state_next;
            tohost_reg <= tohost_next;
        end
    end

    // Only RUNNING reacts to writes; terminal states freeze the mailbox.
    always_comb begin
        state_next  = state_reg;
        tohost_next = tohost_reg;
        if (wr_i && state_reg == ST_RUNNING) begin
            if (&be_i) begin
                tohost_next = wdata_i;
                if (!wdata_i[0])
                    state_next = ST_BADCODE;
                else if (wdata_i == DataWidth'(1))
                    state_next = ST_PASS;
                else
                    state_next = ST_FAIL;
            end else begin
                tohost_next = merged;
            end
        end
    end

    always_comb begin
        status_o = state_reg;
        done_o   = (state_reg != ST_RUNNING);
        tohost_o = tohost_reg;
    end

endmodule

// File: rtl/bare_mem_router.sv
// Request decode, read-data mux, tohost mailbox and sticky error capture for
// the bare-metal harness, fed by the AXI-to-memory bridge's flat request port.
// Ports:
//   clk_i, rst_i                 - clock, asynchronous active-high reset
//   req_i/we_i/addr_i/be_i/wdata_i - request from the bridge
//   rdata_o                      - read data, valid the cycle after req_i
//   rom_*                        - boot ROM read port (1-cycle latency)
//   sram_*                       - main SRAM port (1-cycle latency)
//   tohost_o/status_o/done_o     - mailbox value and pass/fail status
//   err_o/err_addr_o             - sticky bad-access flag and first bad address
module bare_mem_router
    import bare_mem_pkg::*;
#(
    parameter int          AddrWidth    = 64,
    parameter int          DataWidth    = 64,
    parameter int          SramWords    = 16384,
    parameter logic [63:0] RomBase      = DefRomBase,
    parameter logic [63:0] RomLength    = DefRomLength,
    parameter logic [63:0] DramBase     = DefDramBase,
    parameter logic [63:0] DramLength   = DefDramLength,
    parameter logic [63:0] TohostBase   = DefTohostBase,
    parameter logic [63:0] TohostLength = DefTohostLength
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         req_i,
    input  logic                         we_i,
    input  logic [AddrWidth-1:0]         addr_i,
    input  logic [DataWidth/8-1:0]       be_i,
    input  logic [DataWidth-1:0]         wdata_i,
    output logic [DataWidth-1:0]         rdata_o,
    output logic                         rom_req_o,
    output logic [AddrWidth-1:0]         rom_addr_o,
    input  logic [DataWidth-1:0]         rom_rdata_i,
    output logic                         sram_req_o,
    output logic                         sram_we_o,
    output logic [$clog2(SramWords)-1:0] sram_addr_o,
    output logic [DataWidth/8-1:0]       sram_be_o,
    output logic [DataWidth-1:0]         sram_wdata_o,
    input  logic [DataWidth-1:0]         sram_rdata_i,
    output logic [DataWidth-1:0]         tohost_o,
    output logic [1:0]                   status_o,
    output logic                         done_o,
    output logic                         err_o,
    output logic [AddrWidth-1:0]         err_addr_o
);

    localparam int SramAw = $clog2(SramWords);
    localparam int ByteAw = $clog2(DataWidth/8);

    region_e              region, sel_reg;
    logic [AddrWidth-1:0] rom_off, sram_off;
    logic                 bad_access, tohost_wr;
    logic                 err_reg;
    logic [AddrWidth-1:0] err_addr_reg;
    logic [DataWidth-1:0] tohost_val;

    // Priority decode: SRAM, ROM, TOHOST, then UNMAPPED.
    always_comb begin
        region = REGION_UNMAPPED;
        if (in_range((MaxAddrWidth+1)'(addr_i), (MaxAddrWidth+1)'(DramBase),
                     (MaxAddrWidth+1)'(DramLength)))
            region = REGION_SRAM;
        else if (in_range((MaxAddrWidth+1)'(addr_i), (MaxAddrWidth+1)'(RomBase),
                          (MaxAddrWidth+1)'(RomLength)))
            region = REGION_ROM;
        else if (in_range((MaxAddrWidth+1)'(addr_i), (MaxAddrWidth+1)'(TohostBase),
                          (MaxAddrWidth+1)'(TohostLength)))
            region = REGION_TOHOST;
    end

    // Offsets read as zero when the region is not selected.
    always_comb begin
        rom_off  = '0;
        sram_off = '0;
        if (region == REGION_ROM)
            rom_off = AddrWidth'(offset(MaxAddrWidth'(addr_i), RomBase));
        if (region == REGION_SRAM)
            sram_off = AddrWidth'(offset(MaxAddrWidth'(addr_i), DramBase));
    end

    // ROM is read-only: a ROM write is never forwarded and counts as bad.
    assign rom_req_o    = req_i && region == REGION_ROM && !we_i;
    assign rom_addr_o   = rom_off;
    assign sram_req_o   = req_i && region == REGION_SRAM;
    assign sram_we_o    = sram_req_o && we_i;
    assign sram_addr_o  = sram_off[ByteAw +: SramAw];
    assign sram_be_o    = be_i;
    assign sram_wdata_o = wdata_i;

    assign tohost_wr  = req_i && we_i && region == REGION_TOHOST;
    assign bad_access = req_i && (region == REGION_UNMAPPED || (region == REGION_ROM && we_i));

    // sel_reg tracks the target of the last request so the mux lines up with
    // the memories' one-cycle latency; writes update it too.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_reg      <= REGION_UNMAPPED;
            err_reg      <= 1'b0;
            err_addr_reg <= '0;
        end else begin
            if (req_i)
                sel_reg <= region;
            if (bad_access && !err_reg) begin
                err_reg      <= 1'b1;
                err_addr_reg <= addr_i;
            end
        end
    end

    always_comb begin
        unique case (sel_reg)
            REGION_ROM:    rdata_o = rom_rdata_i;
            REGION_SRAM:   rdata_o = sram_rdata_i;
            REGION_TOHOST: rdata_o = tohost_val;
            default:       rdata_o = '0;
        endcase
    end

    bare_tohost_fsm #(
        .DataWidth (DataWidth)
    ) u_tohost (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wr_i     (tohost_wr),
        .be_i     (be_i),
        .wdata_i  (wdata_i),
        .tohost_o (tohost_val),
        .status_o (status_o),
        .done_o   (done_o)
    );

    assign tohost_o   = tohost_val;
    assign err_o      = err_reg;
    assign err_addr_o = err_addr_reg;

endmodule
